// File: rtl/dm_frame_sequencer.sv
// dm_frame_sequencer: walks the DAC shadow RAM one slot at a time (cs-major),
// gathers one word per SPI port, launches all SPI masters together and waits
// for them to finish before moving to the next slot of the frame.
module dm_frame_sequencer #(
    parameter int NPORTS  = 6,
    parameter int NCS     = 4,
    parameter int NCHAN   = 8,
    parameter int DW      = 24,
    parameter int AW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_go,
    input  logic                 frame_abort,
    input  logic                 err_clr,
    output logic                 ram_rd_en,
    output logic [AW-1:0]        ram_addr,
    input  logic [DW-1:0]        ram_rd_data,
    output logic [NPORTS-1:0]    spi_start,
    output logic [NPORTS*DW-1:0] spi_data,
    output logic [1:0]           spi_cs_sel,
    output logic [2:0]           spi_chan,
    input  logic [NPORTS-1:0]    spi_busy,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 err_overrun,
    output logic                 err_timeout
);

    localparam int FW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_LAUNCH,
        ST_ARM,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } stateT;

    stateT                 stateQ, stateD;
    logic [1:0]            csQ;
    logic [2:0]            chanQ;
    logic [FW-1:0]         fetchCnt;
    logic [TW-1:0]         toCnt;
    logic                  capEn;
    logic [FW-1:0]         capIdx;
    logic [NPORTS*DW-1:0]  spiDataQ;
    logic [1:0]            csSelQ;
    logic [2:0]            chanSelQ;
    logic [15:0]           frameCountQ;
    logic                  errOverrunQ;
    logic                  errTimeoutQ;

    logic spiIdle;
    logic lastFetch;
    logic lastSlot;
    logic toExpire;
    logic launchNow;
    logic timeoutEvt;
    logic doneEvt;

    assign spiIdle   = (spi_busy == '0);
    assign lastFetch = (fetchCnt == FW'(NPORTS - 1));
    assign lastSlot  = (csQ == 2'(NCS - 1)) && (chanQ == 3'(NCHAN - 1));
    assign toExpire  = (toCnt == TW'(TIMEOUT - 1));
    assign doneEvt   = (stateQ == ST_DONE) && !frame_abort;

    // Next-state logic plus the launch/timeout events that depend on the transition taken.
    always_comb begin
        // NOTE: every signal driven here gets a default before the case so no path leaves it unassigned, which would infer a latch.
        stateD     = stateQ;
        launchNow  = 1'b0;
        timeoutEvt = 1'b0;
        case (stateQ)
            ST_IDLE:    if (frame_go && !frame_abort) stateD = ST_FETCH;
            ST_FETCH:   if (lastFetch) stateD = ST_CAPTURE;
            ST_CAPTURE: stateD = ST_LAUNCH;
            ST_LAUNCH: begin
                if (spiIdle) begin
                    stateD    = ST_ARM;
                    launchNow = 1'b1;
                end else if (toExpire) begin
                    stateD     = ST_IDLE;
                    timeoutEvt = 1'b1;
                end
            end
            ST_ARM:     stateD = ST_WAIT;
            ST_WAIT: begin
                if (spiIdle) begin
                    stateD = ST_NEXT;
                end else if (toExpire) begin
                    stateD     = ST_IDLE;
                    timeoutEvt = 1'b1;
                end
            end
            ST_NEXT:    stateD = lastSlot ? ST_DONE : ST_FETCH;
            ST_DONE:    stateD = ST_IDLE;
            default:    stateD = ST_IDLE;
        endcase
        // Abort beats everything except reset; a launch or timeout in the same cycle is dropped.
        if (frame_abort && (stateQ != ST_IDLE)) begin
            stateD     = ST_IDLE;
            launchNow  = 1'b0;
            timeoutEvt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (rst) stateQ <= ST_IDLE;
        else     stateQ <= stateD;
    end

    // Slot position (cs, chan): cleared at frame start, advanced in NEXT.
    always_ff @(posedge clk) begin
        if (rst) begin
            csQ   <= '0;
            chanQ <= '0;
        end else if ((stateQ == ST_IDLE) && (stateD == ST_FETCH)) begin
            csQ   <= '0;
            chanQ <= '0;
        end else if ((stateQ == ST_NEXT) && (stateD == ST_FETCH)) begin
            if (chanQ == 3'(NCHAN - 1)) begin
                chanQ <= '0;
                csQ   <= csQ + 2'd1;
            end else begin
                chanQ <= chanQ + 3'd1;
            end
        end
    end

    // FETCH read index and the LAUNCH/WAIT timeout counter, each restarting on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCnt <= '0;
            toCnt    <= '0;
        end else begin
            fetchCnt <= (stateQ == ST_FETCH) ? fetchCnt + FW'(1) : '0;
            if (((stateD == ST_LAUNCH) || (stateD == ST_WAIT)) && (stateD == stateQ))
                toCnt <= toCnt + TW'(1);
            else
                toCnt <= '0;
        end
    end

    // Capture each RAM word into its port lane one cycle after the read; latch slot indices in CAPTURE.
    always_ff @(posedge clk) begin
        // NOTE: the lane storage is reset like control state because spi_data must read zero after rst.
        if (rst) begin
            capEn    <= 1'b0;
            capIdx   <= '0;
            spiDataQ <= '0;
            csSelQ   <= '0;
            chanSelQ <= '0;
        end else begin
            capEn  <= (stateQ == ST_FETCH);
            capIdx <= fetchCnt;
            if (capEn && ((stateQ == ST_FETCH) || (stateQ == ST_CAPTURE)))
                spiDataQ[int'(capIdx)*DW +: DW] <= ram_rd_data;
            if (stateQ == ST_CAPTURE) begin
                csSelQ   <= csQ;
                chanSelQ <= chanQ;
            end
        end
    end

    // Completed-frame counter (wraps at 16 bits) and sticky error flags where a new event beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            frameCountQ <= '0;
            errOverrunQ <= 1'b0;
            errTimeoutQ <= 1'b0;
        end else begin
            if (doneEvt) frameCountQ <= frameCountQ + 16'd1;

            if (frame_go && (stateQ != ST_IDLE)) errOverrunQ <= 1'b1;
            else if (err_clr)                    errOverrunQ <= 1'b0;

            if (timeoutEvt)   errTimeoutQ <= 1'b1;
            else if (err_clr) errTimeoutQ <= 1'b0;
        end
    end

    assign busy        = (stateQ != ST_IDLE);
    assign ram_rd_en   = (stateQ == ST_FETCH);
    assign ram_addr    = ram_rd_en ? AW'((32'(csQ) * NCHAN + 32'(chanQ)) * NPORTS + 32'(fetchCnt)) : '0;
    assign spi_start   = launchNow ? '1 : '0;
    assign spi_data    = spiDataQ;
    assign spi_cs_sel  = csSelQ;
    assign spi_chan    = chanSelQ;
    assign frame_done  = doneEvt;
    assign frame_count = frameCountQ;
    assign err_overrun = errOverrunQ;
    assign err_timeout = errTimeoutQ;

endmodule
